decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_decode_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: single-cycle instruction decoder feeding an in-order output FIFO.
// Each accepted instruction is decoded, checked for privileged-register access
// and queued; out_* always reflect the FIFO head.
// Optional feature: define DECODE_SCOREBOARD_EN to add a 16-entry pending-write
// scoreboard that stalls in_ready on read/write hazards. Without it, wb_valid and
// wb_addr are ignored and there is never a hazard.
module decode_pipe #(
  parameter int          OUT_DEPTH = 2,
  parameter int          PC_W      = 32,
  parameter logic [15:0] PRIV_MASK = 16'hC000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [26:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            in_priv,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [3:0]      wb_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_ra_a,
  output logic [3:0]      out_ra_b,
  output logic [3:0]      out_ra_m,
  output logic [3:0]      out_ra_d,
  output logic [20:0]     out_upper_imm,
  output logic [10:0]     out_lower_imm,
  output logic [6:0]      out_ctl,
  output logic [3:0]      out_aluop,
  output logic            out_fault
);

  // Pointers are sized for the largest legal depth (4).
  localparam int PTR_W = 2;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      ra_a;
    logic [3:0]      ra_b;
    logic [3:0]      ra_m;
    logic [3:0]      ra_d;
    logic [20:0]     upper_imm;
    logic [10:0]     lower_imm;
    logic [6:0]      ctl;
    logic [3:0]      aluop;
    logic            fault;
  } entry_t;

  entry_t     dec;
  logic [1:0] dec_base;
  logic [1:0] dec_sub;
  logic       dec_upper;
  logic       dec_mfmt;
  logic [3:0] dec_func;
  logic       dec_use_imm;
  logic       dec_is_mem;
  logic       hazard;
  logic       push;
  logic       pop;

  // Register n counts as privileged only if nonzero and its mask bit is set.
  function automatic logic is_priv_reg(input logic [3:0] r);
    return (r != 4'd0) && PRIV_MASK[r];
  endfunction

  // Decode the offered instruction combinationally.
  always_comb begin
    dec_base    = in_instr[22:21];
    dec_sub     = {in_instr[20], in_instr[11]};
    dec_upper   = |dec_base;
    dec_mfmt    = ~dec_upper & (dec_sub == 2'b11);
    dec_func    = dec_mfmt ? in_instr[26:23] : in_instr[19:16];
    dec_use_imm = dec_upper | dec_func[3];
    dec_is_mem  = ~dec_upper & dec_sub[1] & dec_func[2] & (dec_func[1:0] != 2'b11);
    dec.pc        = in_pc;
    dec.ra_d      = dec_mfmt ? 4'd0 : in_instr[26:23];
    dec.ra_m      = dec_mfmt ? in_instr[19:16] : 4'd0;
    dec.ra_a      = dec_upper ? 4'd0 : in_instr[15:12];
    dec.ra_b      = dec_use_imm ? 4'd0 : in_instr[3:0];
    dec.upper_imm = in_instr[20:0];
    dec.lower_imm = in_instr[10:0];
    dec.ctl       = {dec_base[1], dec_base[0], dec_upper, dec_use_imm, dec_is_mem,
                     dec_is_mem & dec_mfmt,
                     (dec_base == 2'b01) |
                     ((dec_base == 2'b00) & (dec_sub == 2'b10) & (dec_func[2:0] == 3'b111))};
    dec.aluop     = dec_upper ? 4'd0 : {dec_sub[1], dec_func[2:0]};
    dec.fault     = ~in_priv & (is_priv_reg(dec.ra_a) | is_priv_reg(dec.ra_b) |
                                is_priv_reg(dec.ra_m) | is_priv_reg(dec.ra_d));
  end

  // Output FIFO state.
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  entry_t           mem_q [OUT_DEPTH];
  entry_t           mem_d [OUT_DEPTH];
  entry_t           head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = ~rst & (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = ~rst & ~flush & ~hazard & ((count_q != CNT_W'(OUT_DEPTH)) | pop);
  assign push      = in_valid & in_ready;

  // Outputs read as zero whenever no bundle is presented.
  assign head          = out_valid ? mem_q[head_q] : '0;
  assign out_pc        = head.pc;
  assign out_ra_a      = head.ra_a;
  assign out_ra_b      = head.ra_b;
  assign out_ra_m      = head.ra_m;
  assign out_ra_d      = head.ra_d;
  assign out_upper_imm = head.upper_imm;
  assign out_lower_imm = head.lower_imm;
  assign out_ctl       = head.ctl;
  assign out_aluop     = head.aluop;
  assign out_fault     = head.fault;

  // Next FIFO state: flush empties everything and overrides push/pop.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = dec;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [15:0]          pending_q, pending_d;
  logic [15:0]          wb_clr;
  logic [15:0]          pend_eff;
  logic [OUT_DEPTH-1:0] ent_valid;

  // A slot is live when its distance from the head is below the count.
  for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_ent
    logic [CNT_W-1:0] off;
    assign off = (PTR_W'(gi) >= head_q) ? {1'b0, PTR_W'(gi) - head_q}
                                        : CNT_W'(gi) + CNT_W'(OUT_DEPTH) - {1'b0, head_q};
    assign ent_valid[gi] = off < count_q;
  end

  // A writeback in the same cycle already counts as cleared for hazard purposes.
  assign wb_clr   = wb_valid ? (16'd1 << wb_addr) : 16'd0;
  assign pend_eff = pending_q & ~wb_clr;
  assign hazard   = ((dec.ra_a != 4'd0) & pend_eff[dec.ra_a]) |
                    ((dec.ra_b != 4'd0) & pend_eff[dec.ra_b]) |
                    ((dec.ra_m != 4'd0) & pend_eff[dec.ra_m]) |
                    ((dec.ra_d != 4'd0) & pend_eff[dec.ra_d]);

  // Pending bits: clears first, then the new destination so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q & ~wb_clr;
    if (flush) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        if (ent_valid[i] && !mem_q[i].fault) begin
          pending_d[mem_q[i].ra_d] = 1'b0;
        end
      end
    end else if (push && !dec.fault && (dec.ra_d != 4'd0)) begin
      pending_d[dec.ra_d] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_valid, wb_addr};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the decoder, FIFO and scoreboard.
module tb_decode_pipe;

  localparam int          DEPTH = 2;
  localparam int          PC_W  = 32;
  localparam logic [15:0] PMASK = 16'hC000;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, in_priv, flush, wb_valid, out_valid, out_ready;
  logic [26:0]     in_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [3:0]      wb_addr, out_ra_a, out_ra_b, out_ra_m, out_ra_d, out_aluop;
  logic [20:0]     out_upper_imm;
  logic [10:0]     out_lower_imm;
  logic [6:0]      out_ctl;
  logic            out_fault;

  always #5 clk = ~clk;

  decode_pipe #(.OUT_DEPTH(DEPTH), .PC_W(PC_W), .PRIV_MASK(PMASK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_priv(in_priv), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ra_a(out_ra_a),
    .out_ra_b(out_ra_b), .out_ra_m(out_ra_m), .out_ra_d(out_ra_d),
    .out_upper_imm(out_upper_imm), .out_lower_imm(out_lower_imm), .out_ctl(out_ctl),
    .out_aluop(out_aluop), .out_fault(out_fault)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [3:0]      a, b, m, d;
    logic [20:0]     ui;
    logic [10:0]     li;
    logic [6:0]      ctl;
    logic [3:0]      op;
    logic            fault;
  } exp_t;

  exp_t        q[$];
  exp_t        m_dec;
  logic [15:0] pend;
  logic        m_in_ready, m_out_valid;
  int          n_pass = 0, n_fail = 0, n_total = 0;

  function automatic bit priv_reg(input logic [3:0] r);
    return (r != 4'd0) && PMASK[r];
  endfunction

  // Reference decode, written field by field from the ISA description.
  function automatic exp_t model_decode(input logic [26:0] ins, input logic [PC_W-1:0] pc,
                                        input logic priv);
    exp_t e;
    logic [1:0] base, sub;
    logic [3:0] func;
    logic upper, m_fmt, uimm, mem, jmp;
    base  = ins[22:21];
    sub   = {ins[20], ins[11]};
    upper = (base != 2'd0);
    m_fmt = !upper && (sub == 2'd3);
    func  = m_fmt ? ins[26:23] : ins[19:16];
    uimm  = upper || func[3];
    mem   = !upper && sub[1] && func[2] && (func[1:0] != 2'd3);
    jmp   = (base == 2'd1) || (base == 2'd0 && sub == 2'd2 && func[2:0] == 3'd7);
    e.pc    = pc;
    e.d     = m_fmt ? 4'd0 : ins[26:23];
    e.m     = m_fmt ? ins[19:16] : 4'd0;
    e.a     = upper ? 4'd0 : ins[15:12];
    e.b     = uimm ? 4'd0 : ins[3:0];
    e.ui    = ins[20:0];
    e.li    = ins[10:0];
    e.ctl   = {base[1], base[0], upper, uimm, mem, mem && m_fmt, jmp};
    e.op    = upper ? 4'd0 : {sub[1], func[2:0]};
    e.fault = !priv && (priv_reg(e.a) || priv_reg(e.b) || priv_reg(e.m) || priv_reg(e.d));
    return e;
  endfunction

  function automatic logic [127:0] pack(input exp_t e);
    return 128'({e.pc, e.a, e.b, e.m, e.d, e.ui, e.li, e.ctl, e.op, e.fault});
  endfunction

  function automatic bit model_hazard(input exp_t e);
`ifdef DECODE_SCOREBOARD_EN
    logic [15:0] eff;
    eff = pend;
    if (wb_valid) eff[wb_addr] = 1'b0;
    return (e.a != 0 && eff[e.a]) || (e.b != 0 && eff[e.b]) ||
           (e.m != 0 && eff[e.m]) || (e.d != 0 && eff[e.d]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluate the model for the current inputs and compare visible outputs.
  task automatic settle();
    logic [127:0] dut_bundle;
    #1;
    m_dec       = model_decode(in_instr, in_pc, in_priv);
    m_out_valid = !rst && (q.size() > 0);
    m_in_ready  = !rst && !flush && !model_hazard(m_dec) &&
                  ((q.size() < DEPTH) || (m_out_valid && out_ready));
    dut_bundle  = 128'({out_pc, out_ra_a, out_ra_b, out_ra_m, out_ra_d, out_upper_imm,
                        out_lower_imm, out_ctl, out_aluop, out_fault});
    chk("in_ready", in_ready, m_in_ready);
    chk("out_valid", out_valid, m_out_valid);
    if (m_out_valid) chk("head_bundle", dut_bundle, pack(q[0]));
    else if (rst) chk("rst_outputs_zero", dut_bundle, '0);
  endtask

  // Advance one clock and update the model with the handshakes it predicted.
  task automatic clock();
    @(posedge clk);
    if (rst) begin
      q.delete();
      pend = '0;
    end else begin
      if (wb_valid) pend[wb_addr] = 1'b0;
      if (flush) begin
        foreach (q[i]) if (!q[i].fault) pend[q[i].d] = 1'b0;
        q.delete();
      end else begin
        if (m_out_valid && out_ready) void'(q.pop_front());
        if (in_valid && m_in_ready) begin
          q.push_back(m_dec);
          if (!m_dec.fault && m_dec.d != 4'd0) pend[m_dec.d] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    clock();
  endtask

  task automatic offer(input logic v, input logic [26:0] ins, input logic [PC_W-1:0] pc,
                       input logic priv, input logic ordy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_priv   = priv;
    out_ready = ordy;
  endtask

  initial begin
    pend = '0;
    rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_addr = '0;
    offer(1'b1, 27'h0200005, 32'h40, 1'b1, 1'b1);
    @(negedge clk);
    // Reset with traffic, flush and writeback asserted: nothing may leak through.
    flush = 1'b1; wb_valid = 1'b1;
    cyc(); cyc();
    flush = 1'b0; wb_valid = 1'b0;
    cyc();
    rst = 1'b0;
    offer(1'b0, '0, '0, 1'b1, 1'b0);
    settle();
    chk("ready_after_rst", in_ready, 1'b1);
    clock();

    // Jump encoding: bits[22:21]=01.
    offer(1'b1, 27'h0200005, 32'h100, 1'b1, 1'b0);
    cyc();
    offer(1'b0, '0, '0, 1'b1, 1'b0);
    settle();
    chk("jump_valid", out_valid, 1'b1);
    chk("jump_pc", out_pc, 32'h100);
    chk("jump_is_jump", out_ctl[0], 1'b1);
    chk("jump_aui", out_ctl[5], 1'b1);
    chk("jump_aluop", out_aluop, 4'd0);
    chk("jump_fault", out_fault, 1'b0);
    clock();
    out_ready = 1'b1;
    cyc();

    // Writer of r3 then a reader of r3; the reader waits for the writeback.
    offer(1'b1, 27'd3 << 23, 32'h110, 1'b1, 1'b1);
    cyc();
    offer(1'b1, 27'd3 << 12, 32'h114, 1'b1, 1'b1);
    settle();
`ifdef DECODE_SCOREBOARD_EN
    chk("raw_stall_1", in_ready, 1'b0);
`endif
    clock();
    settle();
`ifdef DECODE_SCOREBOARD_EN
    chk("raw_stall_2", in_ready, 1'b0);
`endif
    clock();
    wb_valid = 1'b1; wb_addr = 4'd3;
    settle();
    chk("raw_release", in_ready, 1'b1);
    clock();
    wb_valid = 1'b0;
    offer(1'b0, '0, '0, 1'b1, 1'b1);
    cyc(); cyc();

    // Fill the FIFO with the consumer stalled, then pop and push together.
    for (int i = 0; i < DEPTH; i++) begin
      offer(1'b1, 27'h0200000 | 27'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      cyc();
    end
    offer(1'b1, 27'h0200007, 32'h200 + 32'(4 * DEPTH), 1'b1, 1'b0);
    settle();
    chk("full_not_ready", in_ready, 1'b0);
    clock();
    out_ready = 1'b1;
    settle();
    chk("full_pop_push_ready", in_ready, 1'b1);
    clock();
    offer(1'b0, '0, '0, 1'b1, 1'b1);
    settle();
    chk("order_after_pop", out_pc, 32'h204);
    clock();
    for (int i = 0; i < DEPTH + 1; i++) cyc();

    // Unprivileged access to r15 faults and leaves r15 untracked.
    offer(1'b1, (27'd15 << 23) | (27'd15 << 12), 32'h300, 1'b0, 1'b0);
    cyc();
    offer(1'b0, '0, '0, 1'b0, 1'b0);
    settle();
    chk("priv_fault", out_fault, 1'b1);
    clock();
    out_ready = 1'b1;
    cyc();
    offer(1'b1, 27'd15 << 12, 32'h304, 1'b1, 1'b1);
    settle();
    chk("r15_not_pending", in_ready, 1'b1);
    clock();
    offer(1'b0, '0, '0, 1'b1, 1'b0);
    settle();
    chk("priv_ok", out_fault, 1'b0);
    clock();
    out_ready = 1'b1;
    cyc();

    // Buffer writers of r5 and r6, flush, then a reader of both must go.
    offer(1'b1, 27'd5 << 23, 32'h400, 1'b1, 1'b0);
    cyc();
    offer(1'b1, 27'd6 << 23, 32'h404, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0; flush = 1'b1;
    settle();
    chk("flush_not_ready", in_ready, 1'b0);
    clock();
    flush = 1'b0;
    offer(1'b1, (27'd5 << 12) | 27'd6, 32'h408, 1'b1, 1'b0);
    settle();
    chk("flush_empty", out_valid, 1'b0);
    chk("flush_cleared_pending", in_ready, 1'b1);
    clock();
    offer(1'b1, 27'h0200001, 32'h40c, 1'b1, 1'b0);
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    offer(1'b0, '0, '0, 1'b1, 1'b1);
    settle();
    chk("rst_midstream_empty", out_valid, 1'b0);
    clock();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = 27'($urandom);
      in_pc     = PC_W'($urandom);
      in_priv   = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      wb_valid  = ($urandom_range(0, 1) == 1);
      wb_addr   = 4'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
